// File: rtl/mult_pkg.sv
// Shared types and core function codes for the multiplier arbiter.
package mult_pkg;

   // Sequencer states, one per phase of the core bus protocol
   typedef enum logic [3:0] {
      StIdle,
      StLoadM,
      StLoadQ,
      StStart,
      StWaitDone,
      StReadLo,
      StReadHi,
      StDone,
      StAbort
   } state_t;

   localparam logic [1:0] FUNC_LOAD_M  = 2'b00;
   localparam logic [1:0] FUNC_LOAD_Q  = 2'b01;
   localparam logic [1:0] FUNC_READ_LO = 2'b10;
   localparam logic [1:0] FUNC_READ_HI = 2'b11;
   // The core loads on 00/01 every clock, so idle must sit on a read code with oe low
   localparam logic [1:0] FUNC_IDLE    = FUNC_READ_LO;

endpackage

// File: rtl/watchdog.sv
// Cycle counter that flags expiry once `limit` consecutive uncleared cycles have elapsed.
module watchdog #(
   parameter int unsigned n_bits = 6,
   parameter int unsigned limit  = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic expired
);

   localparam logic [n_bits-1:0] LastCount = n_bits'(limit - 1);

   logic [n_bits-1:0] count_q;

   // Count up from zero after each clear, holding at the last value once expired
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (!expired) begin
         count_q <= count_q + n_bits'(1);
      end
   end

   assign expired = (count_q == LastCount);

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester arbiter sequencing a shared shift-add multiplier core through load,
// start, wait and read-back, returning the 2n-bit product with a one-cycle ack.
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int unsigned n       = 8,
   parameter int unsigned timeout = 4 * n
) (
   input  logic [0:0]     clock,
   input  logic [0:0]     reset,
   input  logic [1:0]     req,
   input  logic [n-1:0]   m0,
   input  logic [n-1:0]   q0,
   input  logic [n-1:0]   m1,
   input  logic [n-1:0]   q1,
   output logic [1:0]     ack,
   output logic [1:0]     err,
   output logic [2*n-1:0] result,
   output logic [0:0]     busy,
   output logic [1:0]     func,
   output logic [0:0]     oe,
   output logic [0:0]     start,
   input  logic [0:0]     ready,
   output logic [n-1:0]   data_out,
   output logic [0:0]     drive_en,
   input  logic [n-1:0]   data_in
);

   localparam int unsigned WdBits = $clog2(timeout + 1);

   state_t         state_q;
   logic           grant_q;
   logic           favour_q;
   logic [n-1:0]   m_q;
   logic [n-1:0]   q_q;
   logic [2*n-1:0] result_q;
   logic           pick;
   logic           wd_clear;
   logic           wd_expired;

   // Round-robin choice: contested requests go to the requester not served last
   always_comb begin
      pick = req[1];
      if (req == 2'b11) begin
         pick = favour_q;
      end
   end

   // Watchdog runs only while waiting on ready; leaving START restarts it for WAIT_DONE
   always_comb begin
      wd_clear = 1'b1;
      if (state_q == StWaitDone || (state_q == StStart && ready)) begin
         wd_clear = 1'b0;
      end
   end

   watchdog #(
      .n_bits (WdBits),
      .limit  (timeout)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (wd_clear),
      .expired (wd_expired)
   );

   // Sequencer: grant, operand latch, protocol progression and product capture
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         grant_q  <= 1'b0;
         favour_q <= 1'b0;
         m_q      <= '0;
         q_q      <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req != 2'b00) begin
                  grant_q  <= pick;
                  favour_q <= ~pick;
                  m_q      <= pick ? m1 : m0;
                  q_q      <= pick ? q1 : q0;
                  state_q  <= StLoadM;
               end
            end
            StLoadM: state_q <= StLoadQ;
            StLoadQ: state_q <= StStart;
            StStart: begin
               // Progress wins over expiry when both land on the same edge
               if (!ready) begin
                  state_q <= StWaitDone;
               end else if (wd_expired) begin
                  state_q <= StAbort;
               end
            end
            StWaitDone: begin
               if (ready) begin
                  state_q <= StReadLo;
               end else if (wd_expired) begin
                  state_q <= StAbort;
               end
            end
            StReadLo: begin
               result_q[n-1:0] <= data_in;
               state_q         <= StReadHi;
            end
            StReadHi: begin
               result_q[2*n-1:n] <= data_in;
               state_q           <= StDone;
            end
            StDone:  state_q <= StIdle;
            StAbort: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Bus and handshake outputs decoded from the registered state
   always_comb begin
      func     = FUNC_IDLE;
      oe       = 1'b0;
      start    = 1'b0;
      drive_en = 1'b0;
      data_out = '0;
      ack      = 2'b00;
      err      = 2'b00;
      case (state_q)
         StLoadM: begin
            func     = FUNC_LOAD_M;
            drive_en = 1'b1;
            data_out = m_q;
         end
         StLoadQ: begin
            func     = FUNC_LOAD_Q;
            drive_en = 1'b1;
            data_out = q_q;
         end
         StStart:  start = 1'b1;
         StReadLo: begin
            func = FUNC_READ_LO;
            oe   = 1'b1;
         end
         StReadHi: begin
            func = FUNC_READ_HI;
            oe   = 1'b1;
         end
         StDone:   ack[grant_q] = 1'b1;
         StAbort:  err[grant_q] = 1'b1;
         default: ;
      endcase
   end

   assign busy   = (state_q != StIdle);
   assign result = result_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier core.
module tb_mult_arbiter;

   localparam int N       = 8;
   localparam int TIMEOUT = 4 * N;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [1:0]     req   = 2'b00;
   logic [N-1:0]   m0 = '0, q0 = '0, m1 = '0, q1 = '0;
   logic [1:0]     ack, err, func;
   logic [2*N-1:0] result;
   logic           busy, oe, start, drive_en, ready;
   logic [N-1:0]   data_out, data_in;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mult_arbiter #(
      .n       (N),
      .timeout (TIMEOUT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .m0       (m0),
      .q0       (q0),
      .m1       (m1),
      .q1       (q1),
      .ack      (ack),
      .err      (err),
      .result   (result),
      .busy     (busy),
      .func     (func),
      .oe       (oe),
      .start    (start),
      .ready    (ready),
      .data_out (data_out),
      .drive_en (drive_en),
      .data_in  (data_in)
   );

   // Behavioural core: mode 0 normal, 1 ready stuck high, 2 ready never returns
   logic [N-1:0]   core_m = '0, core_q = '0;
   logic [2*N-1:0] core_prod = '0;
   logic           core_ready = 1'b1;
   int             core_cnt = 0;
   int             busy_len = 4;
   int             core_mode = 0;

   always @(posedge clock) begin
      if (drive_en && func == 2'b00) core_m <= data_out;
      if (drive_en && func == 2'b01) core_q <= data_out;
      if (core_cnt == 1) begin
         core_cnt <= 0;
         if (core_mode != 2) core_ready <= 1'b1;
      end else if (core_cnt > 1) begin
         core_cnt <= core_cnt - 1;
      end else if (start && core_ready && core_mode != 1) begin
         core_ready <= 1'b0;
         core_cnt   <= busy_len;
         core_prod  <= {{N{1'b0}}, core_m} * {{N{1'b0}}, core_q};
      end else if (!core_ready && core_mode == 0) begin
         core_ready <= 1'b1;
      end
   end

   assign ready   = core_ready;
   assign data_in = !oe ? '0 : (func == 2'b11 ? core_prod[2*N-1:N] : core_prod[N-1:0]);

   int overlap_cnt = 0;
   always @(negedge clock) if (drive_en && oe) overlap_cnt <= overlap_cnt + 1;

   // Per-cycle bus trace of the current operation, index 0 = first cycle after IDLE
   logic [1:0]   tr_func  [128];
   logic         tr_oe    [128];
   logic         tr_de    [128];
   logic         tr_start [128];
   logic [N-1:0] tr_data  [128];

   // Reference model: last served requester and last completed product
   bit             ref_last   = 1'b1;
   logic [2*N-1:0] ref_result = '0;

   function automatic logic [2*N-1:0] mul(input logic [N-1:0] a, input logic [N-1:0] b);
      return {{N{1'b0}}, a} * {{N{1'b0}}, b};
   endfunction

   function automatic bit ref_pick(input logic [1:0] pat);
      if (pat == 2'b11) return !ref_last;
      return pat[1];
   endfunction

   // The core drops ready one edge after seeing start, so START lasts 2 cycles
   // and WAIT_DONE lasts busy_len cycles: ack at 4 + 2 + busy_len.
   function automatic int exp_lat(input int l);
      return 4 + 2 + l;
   endfunction

   task automatic do_op(input logic [1:0] pat, input int l, input bit drop_at_end,
                        output logic [1:0] got_ack, output logic [1:0] got_err,
                        output int lat, output int start_cycles, output int gap,
                        output bit timed_out);
      bit done;
      busy_len = l;
      req = pat;
      got_ack = '0; got_err = '0; lat = 0; start_cycles = 0; gap = 0;
      timed_out = 1'b0; done = 1'b0;
      @(negedge clock);
      while (!busy && gap < 8) begin
         gap++;
         @(negedge clock);
      end
      while (busy && !done && lat < 200) begin
         if (lat < 128) begin
            tr_func[lat] = func; tr_oe[lat] = oe; tr_de[lat] = drive_en;
            tr_start[lat] = start; tr_data[lat] = data_out;
         end
         if (ack != 2'b00 || err != 2'b00) begin
            got_ack = ack; got_err = err; done = 1'b1;
         end else begin
            if (start) start_cycles++;
            lat++;
            @(negedge clock);
         end
      end
      if (!done) timed_out = 1'b1;
      if (drop_at_end) req = 2'b00;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 2'b00;
      repeat (2) @(negedge clock);
      total++;
      if ({ack, err, busy} !== 5'b0) begin
         bad++; $display("FAIL reset_handshake: got %b want 00000", {ack, err, busy});
      end
      total++;
      if (result !== '0) begin
         bad++; $display("FAIL reset_result: got %h want 0000", result);
      end
      total++;
      if ({func, oe, start, drive_en, data_out} !== {2'b10, 3'b000, {N{1'b0}}}) begin
         bad++; $display("FAIL reset_bus: got %b want 10000 data 0",
                         {func, oe, start, drive_en, data_out});
      end
      reset = 1'b0;
      @(negedge clock);
      total++;
      if ({busy, func, oe, start, drive_en} !== 6'b0_10_000) begin
         bad++; $display("FAIL reset_release_idle: got %b want 010000",
                         {busy, func, oe, start, drive_en});
      end
      ref_last = 1'b1; ref_result = '0;
   endtask

   task automatic test_round_robin();
      logic [1:0] a, e; int lat, sc, gap; bit to, g; logic [2*N-1:0] exp;
      m0 = 8'd3; q0 = 8'd5; m1 = 8'd7; q1 = 8'd9;
      for (int i = 0; i < 3; i++) begin
         g = ref_pick(2'b11);
         exp = g ? mul(m1, q1) : mul(m0, q0);
         do_op(2'b11, 3, (i == 2), a, e, lat, sc, gap, to);
         total++;
         if (to || a !== (g ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr_ack[%0d]: got %b timeout %0d want %b", i, a, to,
                            g ? 2'b10 : 2'b01);
         end
         total++;
         if (result !== exp) begin
            bad++; $display("FAIL rr_result[%0d]: got %0d want %0d", i, result, exp);
         end
         if (i > 0) begin
            total++;
            if (gap !== 1) begin
               bad++; $display("FAIL rr_idle_gap[%0d]: got %0d want 1", i, gap);
            end
         end
         ref_last = g; ref_result = exp;
      end
   endtask

   task automatic test_single();
      logic [1:0] a, e; int lat, sc, gap, idx; bit to;
      m0 = 8'd13; q0 = 8'd11;
      do_op(2'b01, N, 1'b1, a, e, lat, sc, gap, to);
      total++;
      if (to || a !== 2'b01 || e !== 2'b00) begin
         bad++; $display("FAIL single_ack: got ack %b err %b timeout %0d want 01 00", a, e, to);
      end
      total++;
      if (result !== 16'd143) begin
         bad++; $display("FAIL single_result: got %0d want 143", result);
      end
      total++;
      if (lat !== exp_lat(N)) begin
         bad++; $display("FAIL single_latency: got %0d want %0d", lat, exp_lat(N));
      end
      total++;
      if ({tr_func[0], tr_de[0], tr_data[0], tr_func[1], tr_de[1], tr_data[1]} !==
          {2'b00, 1'b1, 8'd13, 2'b01, 1'b1, 8'd11}) begin
         bad++; $display("FAIL single_load_bus: got %b/%0d %b/%0d want 001/13 011/11",
                         {tr_func[0], tr_de[0]}, tr_data[0], {tr_func[1], tr_de[1]}, tr_data[1]);
      end
      total++;
      if ({tr_start[2], tr_func[2], tr_oe[2], tr_de[2]} !== 5'b1_10_0_0) begin
         bad++; $display("FAIL single_start_bus: got %b want 11000",
                         {tr_start[2], tr_func[2], tr_oe[2], tr_de[2]});
      end
      idx = (lat >= 2 && lat < 129) ? lat - 2 : 0;
      total++;
      if ({tr_func[idx], tr_oe[idx], tr_de[idx], tr_func[idx+1], tr_oe[idx+1], tr_de[idx+1]}
          !== 8'b10_1_0_11_1_0) begin
         bad++; $display("FAIL single_read_bus: got %b want 10101110",
                         {tr_func[idx], tr_oe[idx], tr_de[idx],
                          tr_func[idx+1], tr_oe[idx+1], tr_de[idx+1]});
      end
      @(negedge clock);
      total++;
      if ({busy, ack} !== 3'b000) begin
         bad++; $display("FAIL single_after_done: got busy/ack %b want 000", {busy, ack});
      end
      ref_last = 1'b0; ref_result = 16'd143;
   endtask

   task automatic test_ff();
      logic [1:0] a, e; int lat, sc, gap; bit to;
      m1 = 8'hFF; q1 = 8'hFF;
      do_op(2'b10, 5, 1'b1, a, e, lat, sc, gap, to);
      total++;
      if (to || a !== 2'b10 || result !== 16'hFE01) begin
         bad++; $display("FAIL ff_product: got ack %b result %h want 10 fe01", a, result);
      end
      total++;
      if (overlap_cnt !== 0) begin
         bad++; $display("FAIL ff_bus_overlap: got %0d cycles want 0", overlap_cnt);
      end
      ref_last = 1'b1; ref_result = 16'hFE01;
   endtask

   task automatic test_timeout_start();
      logic [1:0] a, e; int lat, sc, gap; bit to;
      core_mode = 1;
      m0 = 8'd2; q0 = 8'd2;
      do_op(2'b01, 4, 1'b1, a, e, lat, sc, gap, to);
      total++;
      if (to || e !== 2'b01 || a !== 2'b00) begin
         bad++; $display("FAIL tmo_start_err: got err %b ack %b want 01 00", e, a);
      end
      total++;
      if (sc !== TIMEOUT || lat !== 2 + TIMEOUT) begin
         bad++; $display("FAIL tmo_start_len: got start %0d abort@%0d want %0d %0d",
                         sc, lat, TIMEOUT, 2 + TIMEOUT);
      end
      total++;
      if (result !== ref_result) begin
         bad++; $display("FAIL tmo_start_result: got %h want %h", result, ref_result);
      end
      @(negedge clock);
      total++;
      if ({busy, err} !== 3'b000) begin
         bad++; $display("FAIL tmo_start_idle: got busy/err %b want 000", {busy, err});
      end
      ref_last = 1'b0;
      core_mode = 0;
   endtask

   task automatic test_timeout_wait();
      logic [1:0] a, e; int lat, sc, gap; bit to;
      core_mode = 2;
      m1 = 8'd4; q1 = 8'd4;
      do_op(2'b10, 3, 1'b1, a, e, lat, sc, gap, to);
      total++;
      if (to || e !== 2'b10 || lat !== 4 + TIMEOUT || result !== ref_result) begin
         bad++; $display("FAIL tmo_wait: got err %b abort@%0d result %h want 10 %0d %h",
                         e, lat, result, 4 + TIMEOUT, ref_result);
      end
      ref_last = 1'b1;
      core_mode = 0;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_random();
      logic [1:0] a, e, pat; int lat, sc, gap, l; bit to, g; logic [2*N-1:0] exp;
      for (int i = 0; i < 20; i++) begin
         m0 = N'($urandom); q0 = N'($urandom); m1 = N'($urandom); q1 = N'($urandom);
         pat = 2'($urandom_range(1, 3));
         l = $urandom_range(1, 10);
         g = ref_pick(pat);
         exp = g ? mul(m1, q1) : mul(m0, q0);
         do_op(pat, l, 1'b1, a, e, lat, sc, gap, to);
         total++;
         if (to || a !== (g ? 2'b10 : 2'b01) || result !== exp || lat !== exp_lat(l)) begin
            bad++; $display("FAIL rand[%0d]: req %b got ack %b result %h lat %0d want %b %h %0d",
                            i, pat, a, result, lat, g ? 2'b10 : 2'b01, exp, exp_lat(l));
         end
         ref_last = g; ref_result = exp;
         @(negedge clock);
      end
      total++;
      if (overlap_cnt !== 0) begin
         bad++; $display("FAIL rand_bus_overlap: got %0d cycles want 0", overlap_cnt);
      end
   endtask

   task automatic test_drop();
      int n_ack, w; logic [2*N-1:0] cap;
      m0 = 8'd10; q0 = 8'd12; busy_len = 6; req = 2'b01;
      w = 0;
      while (!start && w < 20) begin @(negedge clock); w++; end
      while (start && w < 40) begin @(negedge clock); w++; end
      req = 2'b00;
      n_ack = 0; cap = '0;
      for (int c = 0; c < 30; c++) begin
         if (ack != 2'b00) begin
            n_ack++;
            cap = result;
            total++;
            if (ack !== 2'b01) begin
               bad++; $display("FAIL drop_ack_id: got %b want 01", ack);
            end
         end
         @(negedge clock);
      end
      total++;
      if (n_ack !== 1 || cap !== 16'd120) begin
         bad++; $display("FAIL drop_complete: got %0d acks result %0d want 1 120", n_ack, cap);
      end
      ref_last = 1'b0; ref_result = 16'd120;
   endtask

   task automatic test_reset_mid();
      logic [1:0] a, e; int lat, sc, gap, w, stray; bit to;
      m0 = 8'd6; q0 = 8'd7; busy_len = 8; req = 2'b01;
      w = 0;
      while (!start && w < 20) begin @(negedge clock); w++; end
      while (start && w < 40) begin @(negedge clock); w++; end
      reset = 1'b1; req = 2'b00;
      @(negedge clock);
      total++;
      if ({busy, ack, err, start, oe, drive_en, func, data_out, result} !==
          {7'b0, 2'b10, {N{1'b0}}, {2*N{1'b0}}}) begin
         bad++; $display("FAIL midreset_outputs: busy %b ack %b err %b bus %b data %h result %h",
                         busy, ack, err, {start, oe, drive_en, func}, data_out, result);
      end
      reset = 1'b0;
      stray = 0;
      for (int c = 0; c < 20; c++) begin
         if (ack != 2'b00 || err != 2'b00 || busy) stray++;
         @(negedge clock);
      end
      total++;
      if (stray !== 0) begin
         bad++; $display("FAIL midreset_quiet: got %0d active cycles want 0", stray);
      end
      ref_last = 1'b1; ref_result = '0;
      m1 = 8'd2; q1 = 8'd3;
      do_op(2'b11, 2, 1'b1, a, e, lat, sc, gap, to);
      total++;
      if (to || a !== 2'b01 || result !== mul(m0, q0)) begin
         bad++; $display("FAIL midreset_ptr: got ack %b result %0d want 01 %0d",
                         a, result, mul(m0, q0));
      end
      ref_last = 1'b0;
      @(negedge clock);
      do_op(2'b10, 2, 1'b1, a, e, lat, sc, gap, to);
      total++;
      if (to || a !== 2'b10 || result !== mul(m1, q1)) begin
         bad++; $display("FAIL midreset_req1: got ack %b result %0d want 10 %0d",
                         a, result, mul(m1, q1));
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_ff();
      test_timeout_start();
      test_timeout_wait();
      test_random();
      test_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

endmodule
